hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
- REQ-001: Parameter FWD_DEPTH, default 3; number of forwarding sources, legal 1..3 (1=EX, 2=+DM, 3=+WB).
- REQ-002: Parameter R0_ZERO, default 1; 1 = register 0 is hardwired zero and never forwarded.
- REQ-003: Parameter LOAD_STALL, default 1; 1 = load-use stall enabled, 0 = detection disabled, stall tied 0.
- REQ-004: clk  in  1  sole clock, rising edge.
- REQ-005: reset  in  1  synchronous, active-low reset.
- REQ-006: ins  in  32  instruction: op[31:26], RW[25:21], RA[20:16], RB[15:11], imm[15:0].
- REQ-007: ins_valid  in  1  ins is a real instruction; 0 = bubble.
- REQ-008: stall  out  1  combinational; ins not accepted this cycle, source must hold ins.
- REQ-009: op_dec  out  6  opcode in EX stage.
- REQ-010: imm  out  16  immediate in EX stage.
- REQ-011: imm_sel  out  1  EX operand B is imm.
- REQ-012: mux_sel_A, mux_sel_B  out  2 each  EX operand source: 0 RF, 1 EX result, 2 DM result, 3 WB result.
- REQ-013: mem_en_ex, mem_rw_ex  out  1 each  memory enable / write (1=write) for the EX instruction.
- REQ-014: RW_dm  out  5  destination register of DM-stage instruction.
- REQ-015: mem_mux_sel_dm  out  1  DM result is memory data (load) vs ALU result.

Function
- REQ-016: Opcode class by op[5:3]: 000 ALU reg-reg, 001 ALU imm, 010 LOAD, 011 STORE, other = NOP.
- REQ-017: Writers = ALU, ALUI, LOAD; STORE, NOP and bubbles have no destination and never match.
- REQ-018: Three internal stages EX, DM, WB hold {valid, class, RW}; they advance every cycle.
- REQ-019: ins accepted at a rising edge with ins_valid=1, stall=0, reset=1 is loaded into EX; its outputs are visible after that edge (latency 1); it reaches DM after edge 2, WB after edge 3.
- REQ-020: Reads: RA for ALU/ALUI/LOAD/STORE; RB for ALU and STORE (store data); no reads for NOP.
- REQ-021: mux_sel_A = smallest k in 1..FWD_DEPTH whose stage (EX,DM,WB) holds a valid writer with RW==RA; else 0; nearest stage wins.
- REQ-022: mux_sel_B computed identically with RB; forced 0 when imm_sel=1.
- REQ-023: R0_ZERO=1: source register 0 always gives select 0.
- REQ-024: imm_sel=1 for ALUI, LOAD; mem_en_ex=1 for LOAD/STORE; mem_rw_ex=1 for STORE only.
- REQ-025: Load-use: LOAD_STALL=1 and EX holds valid LOAD with RW matching a read of ins (R0 excluded when R0_ZERO=1) -> stall=1.
- REQ-026: On stall, ins not accepted; EX loaded with bubble (op_dec=0, imm=0, imm_sel=0, mux_sels=0, mem_en_ex=0, mem_rw_ex=0); load proceeds to DM.
- REQ-027: Stall lasts exactly one cycle per load; next cycle same ins is accepted with select 2 toward the load.
- REQ-028: FWD_DEPTH < 3: matches in stages beyond depth ignored (select 0; RF write-through assumed).
- REQ-029: ins_valid=0 with stall=0 loads bubble into EX; stall never asserted for ins_valid=0.
- REQ-030: RW_dm, mem_mux_sel_dm registered from EX each cycle; mem_mux_sel_dm=1 iff DM holds valid LOAD.

Reset
- REQ-031: reset=0 at a rising edge clears all stages to bubble; all outputs 0, stall 0 the following cycle.
- REQ-032: reset mid-stall: reset wins; held instruction dropped, source re-presents after reset.
- REQ-033: Hazard state never survives reset: first instruction after reset forwards from nothing (selects 0).

Verification
- REQ-034: ins=0x00221800 (ALU r1,r2,r3) after reset -> next cycle op_dec=0, mux_sel_A=0, mux_sel_B=0, stall=0.
- REQ-035: LOAD r4<-[r1] (0x50810000) then ALU r5=r1+r4 (0x10A12000) -> stall=1 one cycle, bubble in EX, then ALU accepted with mux_sel_B=2, mux_sel_A=0, RW_dm=4, mem_mux_sel_dm=1.
- REQ-036: ALU r6 writes, then ALUI r7=r6+5 next cycle -> mux_sel_A=1, imm_sel=1, mux_sel_B=0; same with one bubble between -> mux_sel_A=2; two bubbles -> 3 (FWD_DEPTH=3) or 0 (FWD_DEPTH=2).
- REQ-037: R0_ZERO=1: ALU writing r0 followed by reader of r0 -> selects 0, no stall.
- REQ-038: EX and DM both write r1, reader of r1 -> mux_sel_A=1 (nearest).
- REQ-039: reset=0 during stall cycle -> next cycle all outputs 0, stall=0, load not in DM.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding control for a three-stage (EX/DM/WB) pipeline.
// Decodes the incoming instruction, selects bypass sources and inserts one bubble per load-use hazard.
module hazard_forward_unit #(
    parameter int FWD_DEPTH  = 3,
    parameter int R0_ZERO    = 1,
    parameter int LOAD_STALL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        ins_valid,
    output logic        stall,
    output logic [5:0]  op_dec,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic [1:0]  mux_sel_A,
    output logic [1:0]  mux_sel_B,
    output logic        mem_en_ex,
    output logic        mem_rw_ex,
    output logic [4:0]  RW_dm,
    output logic        mem_mux_sel_dm
);

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_ALUI  = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_NOP   = 3'd4
    } cls_e;

    typedef struct packed {
        logic       valid;
        cls_e       cls;
        logic [4:0] rw;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, cls: CLS_NOP, rw: 5'd0};

    stage_t      ex_q, dm_q, wb_q, ex_d;
    logic [5:0]  op_dec_q, op_dec_d;
    logic [15:0] imm_q, imm_d;
    logic        imm_sel_q, imm_sel_d;
    logic [1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic        mem_en_q, mem_en_d, mem_rw_q, mem_rw_d;

    cls_e       in_cls;
    logic [4:0] in_rw, in_ra, in_rb;
    logic       reads_a, reads_b, accept;

    function automatic logic is_writer(input stage_t s);
        return s.valid && (s.cls inside {CLS_ALU, CLS_ALUI, CLS_LOAD});
    endfunction

    function automatic logic is_r0(input logic [4:0] r);
        return (R0_ZERO != 0) && (r == 5'd0);
    endfunction

    // Nearest producer wins; stages beyond FWD_DEPTH rely on register-file write-through.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input stage_t ex,
                                           input stage_t dm, input stage_t wb);
        if (is_r0(r))                                          return 2'd0;
        if (FWD_DEPTH >= 1 && is_writer(ex) && ex.rw == r)     return 2'd1;
        if (FWD_DEPTH >= 2 && is_writer(dm) && dm.rw == r)     return 2'd2;
        if (FWD_DEPTH >= 3 && is_writer(wb) && wb.rw == r)     return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic load_hit(input logic [4:0] r, input stage_t ex);
        return ex.valid && (ex.cls == CLS_LOAD) && (ex.rw == r) && !is_r0(r);
    endfunction

    always_comb begin
        in_rw = ins[25:21];
        in_ra = ins[20:16];
        in_rb = ins[15:11];
        case (ins[31:29])
            3'b000:  in_cls = CLS_ALU;
            3'b001:  in_cls = CLS_ALUI;
            3'b010:  in_cls = CLS_LOAD;
            3'b011:  in_cls = CLS_STORE;
            default: in_cls = CLS_NOP;
        endcase
        reads_a = (in_cls != CLS_NOP);
        reads_b = (in_cls == CLS_ALU) || (in_cls == CLS_STORE);
    end

    always_comb begin
        stall = (LOAD_STALL != 0) && ins_valid &&
                ((reads_a && load_hit(in_ra, ex_q)) || (reads_b && load_hit(in_rb, ex_q)));
        accept = ins_valid && !stall;

        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        ex_d      = BUBBLE;
        op_dec_d  = 6'd0;
        imm_d     = 16'd0;
        imm_sel_d = 1'b0;
        sel_a_d   = 2'd0;
        sel_b_d   = 2'd0;
        mem_en_d  = 1'b0;
        mem_rw_d  = 1'b0;

        if (accept) begin
            ex_d      = '{valid: 1'b1, cls: in_cls, rw: in_rw};
            op_dec_d  = ins[31:26];
            imm_d     = ins[15:0];
            imm_sel_d = (in_cls == CLS_ALUI) || (in_cls == CLS_LOAD);
            mem_en_d  = (in_cls == CLS_LOAD) || (in_cls == CLS_STORE);
            mem_rw_d  = (in_cls == CLS_STORE);
            sel_a_d   = reads_a ? fwd_sel(in_ra, ex_q, dm_q, wb_q) : 2'd0;
            sel_b_d   = reads_b ? fwd_sel(in_rb, ex_q, dm_q, wb_q) : 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the EX->DM->WB shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q      <= BUBBLE;
            dm_q      <= BUBBLE;
            wb_q      <= BUBBLE;
            op_dec_q  <= 6'd0;
            imm_q     <= 16'd0;
            imm_sel_q <= 1'b0;
            sel_a_q   <= 2'd0;
            sel_b_q   <= 2'd0;
            mem_en_q  <= 1'b0;
            mem_rw_q  <= 1'b0;
        end else begin
            wb_q      <= dm_q;
            dm_q      <= ex_q;
            ex_q      <= ex_d;
            op_dec_q  <= op_dec_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            mem_en_q  <= mem_en_d;
            mem_rw_q  <= mem_rw_d;
        end
    end

    assign op_dec         = op_dec_q;
    assign imm            = imm_q;
    assign imm_sel        = imm_sel_q;
    assign mux_sel_A      = sel_a_q;
    assign mux_sel_B      = sel_b_q;
    assign mem_en_ex      = mem_en_q;
    assign mem_rw_ex      = mem_rw_q;
    assign RW_dm          = dm_q.rw;
    assign mem_mux_sel_dm = dm_q.valid && (dm_q.cls == CLS_LOAD);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a default (depth 3) instance and a depth-2 instance share
// one instruction stream; all expected values are hand-derived from the instruction encodings.
module tb_hazard_forward_unit;

    localparam logic [5:0] OP_ALU   = 6'b000_000;
    localparam logic [5:0] OP_ALUI  = 6'b001_000;
    localparam logic [5:0] OP_LOAD  = 6'b010_000;
    localparam logic [5:0] OP_STORE = 6'b011_000;

    logic        clk;
    logic        reset;
    logic [31:0] ins;
    logic        ins_valid;

    logic        stall, imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm;
    logic [5:0]  op_dec;
    logic [15:0] imm;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic [4:0]  RW_dm;

    logic        d2_stall, d2_imm_sel, d2_mem_en_ex, d2_mem_rw_ex, d2_mem_mux_sel_dm;
    logic [5:0]  d2_op_dec;
    logic [15:0] d2_imm;
    logic [1:0]  d2_mux_sel_A, d2_mux_sel_B;
    logic [4:0]  d2_RW_dm;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid),
        .stall(stall), .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel),
        .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .RW_dm(RW_dm), .mem_mux_sel_dm(mem_mux_sel_dm)
    );

    hazard_forward_unit #(.FWD_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid),
        .stall(d2_stall), .op_dec(d2_op_dec), .imm(d2_imm), .imm_sel(d2_imm_sel),
        .mux_sel_A(d2_mux_sel_A), .mux_sel_B(d2_mux_sel_B),
        .mem_en_ex(d2_mem_en_ex), .mem_rw_ex(d2_mem_rw_ex),
        .RW_dm(d2_RW_dm), .mem_mux_sel_dm(d2_mem_mux_sel_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rw,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {op, rw, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rw,
                                         input logic [4:0] ra, input logic [15:0] im);
        return {op, rw, ra, im};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i, input logic v);
        ins       = i;
        ins_valid = v;
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        ins_valid = 1'b0;
        ins       = 32'd0;
        tick();
        reset = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " op_dec"},  {26'd0, op_dec}, 32'd0);
        check({tag, " imm"},     {16'd0, imm}, 32'd0);
        check({tag, " imm_sel"}, {31'd0, imm_sel}, 32'd0);
        check({tag, " sel_A"},   {30'd0, mux_sel_A}, 32'd0);
        check({tag, " sel_B"},   {30'd0, mux_sel_B}, 32'd0);
        check({tag, " mem_en"},  {31'd0, mem_en_ex}, 32'd0);
        check({tag, " mem_rw"},  {31'd0, mem_rw_ex}, 32'd0);
        check({tag, " RW_dm"},   {27'd0, RW_dm}, 32'd0);
        check({tag, " mem_mux"}, {31'd0, mem_mux_sel_dm}, 32'd0);
        check({tag, " stall"},   {31'd0, stall}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        ins       = 32'd0;
        ins_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check_idle("reset");

        // ALU r1 = r2 op r3: opcode 0, no producers in flight
        present(32'h0022_1800, 1'b1);
        check("alu stall", {31'd0, stall}, 32'd0);
        tick();
        check("alu op_dec", {26'd0, op_dec}, 32'd0);
        check("alu sel_A", {30'd0, mux_sel_A}, 32'd0);
        check("alu sel_B", {30'd0, mux_sel_B}, 32'd0);
        check("alu imm", {16'd0, imm}, 32'h1800);

        // load-use: LOAD r4<-[r1] then ALU r5 = r1 + r4
        do_reset();
        present(32'h5081_0000, 1'b1);
        tick();
        check("ld op_dec", {26'd0, op_dec}, 32'h14);
        check("ld imm_sel", {31'd0, imm_sel}, 32'd1);
        check("ld mem_en", {31'd0, mem_en_ex}, 32'd1);
        check("ld mem_rw", {31'd0, mem_rw_ex}, 32'd0);
        present(32'h10A1_2000, 1'b0);
        check("ld novalid stall", {31'd0, stall}, 32'd0);
        present(32'h10A1_2000, 1'b1);
        check("lu stall", {31'd0, stall}, 32'd1);
        tick();
        check("bub op_dec", {26'd0, op_dec}, 32'd0);
        check("bub mem_en", {31'd0, mem_en_ex}, 32'd0);
        check("bub imm_sel", {31'd0, imm_sel}, 32'd0);
        check("bub RW_dm", {27'd0, RW_dm}, 32'd4);
        check("bub mem_mux", {31'd0, mem_mux_sel_dm}, 32'd1);
        check("bub stall", {31'd0, stall}, 32'd0);
        tick();
        check("lu op_dec", {26'd0, op_dec}, 32'h04);
        check("lu sel_A", {30'd0, mux_sel_A}, 32'd0);
        check("lu sel_B", {30'd0, mux_sel_B}, 32'd2);
        check("lu mem_mux", {31'd0, mem_mux_sel_dm}, 32'd0);
        present(32'd0, 1'b0);

        // load-use on store data (RB)
        do_reset();
        present(32'h5081_0000, 1'b1);
        tick();
        present(mk_r(OP_STORE, 5'd0, 5'd1, 5'd4), 1'b1);
        check("st lu stall", {31'd0, stall}, 32'd1);

        // forwarding distance: 0, 1, 2 bubbles between ALU r6 and ALUI r7 = r6 + 5
        for (int gap = 0; gap < 3; gap++) begin
            logic [1:0] exp3, exp2;
            exp3 = 2'(gap + 1);
            exp2 = (gap < 2) ? 2'(gap + 1) : 2'd0;
            do_reset();
            present(mk_r(OP_ALU, 5'd6, 5'd1, 5'd2), 1'b1);
            tick();
            for (int b = 0; b < gap; b++) begin
                present(32'd0, 1'b0);
                tick();
            end
            present(mk_i(OP_ALUI, 5'd7, 5'd6, 16'd5), 1'b1);
            check($sformatf("fwd%0d stall", gap), {31'd0, stall}, 32'd0);
            tick();
            check($sformatf("fwd%0d sel_A", gap), {30'd0, mux_sel_A}, {30'd0, exp3});
            check($sformatf("fwd%0d d2 sel_A", gap), {30'd0, d2_mux_sel_A}, {30'd0, exp2});
            check($sformatf("fwd%0d imm_sel", gap), {31'd0, imm_sel}, 32'd1);
            check($sformatf("fwd%0d sel_B", gap), {30'd0, mux_sel_B}, 32'd0);
            check($sformatf("fwd%0d imm", gap), {16'd0, imm}, 32'd5);
        end

        // r0 is never forwarded and never stalls
        do_reset();
        present(mk_r(OP_ALU, 5'd0, 5'd1, 5'd2), 1'b1);
        tick();
        present(mk_r(OP_ALU, 5'd3, 5'd0, 5'd0), 1'b1);
        tick();
        check("r0 sel_A", {30'd0, mux_sel_A}, 32'd0);
        check("r0 sel_B", {30'd0, mux_sel_B}, 32'd0);
        do_reset();
        present(mk_i(OP_LOAD, 5'd0, 5'd1, 16'd0), 1'b1);
        tick();
        present(mk_r(OP_ALU, 5'd3, 5'd0, 5'd0), 1'b1);
        check("r0 ld stall", {31'd0, stall}, 32'd0);

        // EX and DM both write r1: nearest wins; store data via RB
        do_reset();
        present(mk_r(OP_ALU, 5'd1, 5'd2, 5'd3), 1'b1);
        tick();
        present(mk_i(OP_ALUI, 5'd1, 5'd2, 16'd9), 1'b1);
        tick();
        present(mk_r(OP_ALU, 5'd4, 5'd1, 5'd2), 1'b1);
        tick();
        check("near sel_A", {30'd0, mux_sel_A}, 32'd1);
        check("near sel_B", {30'd0, mux_sel_B}, 32'd0);
        present(mk_r(OP_STORE, 5'd0, 5'd2, 5'd1), 1'b1);
        tick();
        check("st sel_B", {30'd0, mux_sel_B}, 32'd2);
        check("st sel_A", {30'd0, mux_sel_A}, 32'd0);
        check("st mem_en", {31'd0, mem_en_ex}, 32'd1);
        check("st mem_rw", {31'd0, mem_rw_ex}, 32'd1);
        check("st imm_sel", {31'd0, imm_sel}, 32'd0);

        // reset during a stall cycle drops everything
        do_reset();
        present(32'h5081_0000, 1'b1);
        tick();
        present(32'h10A1_2000, 1'b1);
        check("rs stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        present(32'h10A1_2000, 1'b0);
        check_idle("rs");
        present(32'h10A1_2000, 1'b1);
        check("rs re stall", {31'd0, stall}, 32'd0);
        tick();
        check("rs re op_dec", {26'd0, op_dec}, 32'h04);
        check("rs re sel_A", {30'd0, mux_sel_A}, 32'd0);
        check("rs re sel_B", {30'd0, mux_sel_B}, 32'd0);
        check("rs re mem_mux", {31'd0, mem_mux_sel_dm}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
